// File: rtl/matmul_arbiter_pkg.sv
// Shared element constants, FSM encoding and packed-slice helper for the matmul arbiter.
`ifndef MM_SLICE
`define MM_SLICE(idx, width) (idx)*(width) +: (width)
`endif

package matmul_defs;

  localparam int          ELEM_W = 32;
  localparam logic [31:0] FP_ONE = 32'h3f800000;
  localparam logic [31:0] FP_TWO = 32'h40000000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/matmul_arbiter_rr_pick.sv
// Combinational round-robin select: first set request after the pointer, wrapping modulo N.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_oh,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  always_comb begin
    o_oh  = '0;
    o_idx = '0;
    o_any = 1'b0;
    // Offset N lands back on the pointer itself, so it is the lowest-priority candidate.
    for (int off = 1; off <= N; off++) begin
      int cand;
      cand = (int'(i_ptr) + off) % N;
      if (!o_any && i_req[cand]) begin
        o_any      = 1'b1;
        o_idx      = IW'(cand);
        o_oh[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/matmul_arbiter.sv
// Shares one matmul between N requesters: round-robin grant, operand latch, start/done sequencing.
// Optional WAIT-state timeout is compiled in with MATMUL_ARB_TIMEOUT_EN.
module matmul_arbiter
  import matmul_defs::*;
#(
  parameter int N       = 2,
  parameter int S       = ELEM_W,
  parameter int H       = 4,
  parameter int W       = 1,
  parameter int C       = 2,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       req,
  input  logic [N*H*C*S-1:0] req_a,
  input  logic [N*C*W*S-1:0] req_b,
  output logic [N-1:0]       gnt,
  output logic [N-1:0]       rsp_valid,
  output logic [H*W*S-1:0]   rsp_o,
  output logic               rsp_err,
  output logic               busy,
  output logic               mm_rst_n,
  output logic               mm_start,
  output logic [H*C*S-1:0]   mm_a,
  output logic [C*W*S-1:0]   mm_b,
  input  logic [H*W*S-1:0]   mm_o,
  input  logic               mm_done
);

  localparam int IW  = $clog2(N);
  localparam int AW  = H*C*S;
  localparam int BW  = C*W*S;

  if (N < 2 || N > 8) begin : g_bad_n
    $error("matmul_arbiter: N must be within 2..8");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("matmul_arbiter: TIMEOUT must be at least 1");
  end

  arb_state_t         r_state;
  logic [IW-1:0]      r_ptr;
  logic [N-1:0]       r_k_oh;
  logic [N-1:0]       r_gnt;
  logic [N-1:0]       r_vld;
  logic [H*W*S-1:0]   r_rsp_o;
  logic               r_busy;
  logic               r_mm_rst_n;
  logic               r_mm_start;
  logic [AW-1:0]      r_mm_a;
  logic [BW-1:0]      r_mm_b;

  logic [N-1:0]       w_oh;
  logic [IW-1:0]      w_idx;
  logic               w_any;

`ifdef MATMUL_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  logic          r_err;
  assign rsp_err = r_err;
`else
  assign rsp_err = 1'b0;
`endif

  rr_pick #(.N(N), .IW(IW)) u_rr_pick (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_oh  (w_oh),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_ptr      <= IW'(N - 1);
      r_k_oh     <= '0;
      r_gnt      <= '0;
      r_vld      <= '0;
      r_rsp_o    <= '0;
      r_busy     <= 1'b0;
      r_mm_rst_n <= 1'b0;
      r_mm_start <= 1'b0;
      r_mm_a     <= '0;
      r_mm_b     <= '0;
`ifdef MATMUL_ARB_TIMEOUT_EN
      r_cnt      <= '0;
      r_err      <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_mm_a     <= req_a[`MM_SLICE(int'(w_idx), AW)];
            r_mm_b     <= req_b[`MM_SLICE(int'(w_idx), BW)];
            r_ptr      <= w_idx;
            r_k_oh     <= w_oh;
            r_gnt      <= w_oh;
            r_mm_start <= 1'b1;
            r_mm_rst_n <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_ISSUE;
          end
        end
        // Holding matmul in reset here also clears a done left over from the previous operation.
        ST_ISSUE: begin
          r_gnt      <= '0;
          r_mm_start <= 1'b0;
          r_mm_rst_n <= 1'b1;
`ifdef MATMUL_ARB_TIMEOUT_EN
          r_cnt      <= '0;
`endif
          r_state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mm_done) begin
            r_rsp_o <= mm_o;
            r_vld   <= r_k_oh;
            r_state <= ST_RESP;
          end
`ifdef MATMUL_ARB_TIMEOUT_EN
          else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_rsp_o <= '0;
            r_err   <= 1'b1;
            r_vld   <= r_k_oh;
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          r_vld   <= '0;
          r_busy  <= 1'b0;
`ifdef MATMUL_ARB_TIMEOUT_EN
          r_err   <= 1'b0;
`endif
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign rsp_valid = r_vld;
  assign rsp_o     = r_rsp_o;
  assign busy      = r_busy;
  assign mm_rst_n  = r_mm_rst_n;
  assign mm_start  = r_mm_start;
  assign mm_a      = r_mm_a;
  assign mm_b      = r_mm_b;

endmodule

// File: tb/tb_matmul_arbiter.sv
// Directed bench for matmul_arbiter: cycle table for arbitration/handshake, hand sequences for reset abort and stalled matmul.
module tb_matmul_arbiter;
  import matmul_defs::*;

  localparam int N = 2, S = 32, H = 4, W = 1, C = 2;
  localparam int AW = H*C*S, BW = C*W*S, OW = H*W*S;

  localparam logic [AW-1:0] A0 = {8{FP_ONE}};
  localparam logic [BW-1:0] B0 = {2{FP_ONE}};
  localparam logic [OW-1:0] O0 = {4{FP_TWO}};
  localparam logic [AW-1:0] A1 = {8{FP_TWO}};
  localparam logic [BW-1:0] B1 = {2{FP_ONE}};
  localparam logic [OW-1:0] O1 = {4{32'h40800000}};

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N-1:0]       req;
  logic [N*AW-1:0]    req_a;
  logic [N*BW-1:0]    req_b;
  logic [N-1:0]       gnt, rsp_valid;
  logic [OW-1:0]      rsp_o, mm_o;
  logic               rsp_err, busy, mm_rst_n, mm_start, mm_done;
  logic [AW-1:0]      mm_a;
  logic [BW-1:0]      mm_b;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  matmul_arbiter #(.N(N), .S(S), .H(H), .W(W), .C(C), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_o(rsp_o), .rsp_err(rsp_err), .busy(busy),
    .mm_rst_n(mm_rst_n), .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b),
    .mm_o(mm_o), .mm_done(mm_done)
  );

  // Stand-in datapath: returns the hand-computed product for each known operand set.
  always_comb begin
    mm_o = '0;
    if (mm_a == A0 && mm_b == B0) mm_o = O0;
    else if (mm_a == A1 && mm_b == B1) mm_o = O1;
  end

  typedef struct {
    logic       rst;
    logic [1:0] rq;
    logic       dn;
    logic [1:0] g;
    logic [1:0] v;
    logic       b;
    logic       st;
    logic       mr;
    logic [1:0] osel;
  } vec_t;

  function automatic vec_t mk(logic rst, logic [1:0] rq, logic dn, logic [1:0] g, logic [1:0] v,
                              logic b, logic st, logic mr, logic [1:0] osel);
    vec_t t;
    t.rst = rst; t.rq = rq; t.dn = dn; t.g = g; t.v = v;
    t.b = b; t.st = st; t.mr = mr; t.osel = osel;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[40];

  initial begin
    logic [OW-1:0] exp_o;

    // rst, req, done | gnt, vld, busy, start, mm_rst_n, rsp_o select (0 none, 1 O0, 2 O1, 3 zero)
    tbl[0]  = mk(0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 3);
    tbl[1]  = mk(1, 2'b11, 0, 2'b01, 2'b00, 1, 1, 0, 0);
    tbl[2]  = mk(1, 2'b10, 0, 2'b00, 2'b00, 1, 0, 1, 0);
    tbl[3]  = mk(1, 2'b10, 1, 2'b00, 2'b01, 1, 0, 1, 1);
    tbl[4]  = mk(1, 2'b10, 0, 2'b00, 2'b00, 0, 0, 1, 0);
    tbl[5]  = mk(1, 2'b10, 0, 2'b10, 2'b00, 1, 1, 0, 0);
    tbl[6]  = mk(1, 2'b00, 0, 2'b00, 2'b00, 1, 0, 1, 0);
    tbl[7]  = mk(1, 2'b00, 1, 2'b00, 2'b10, 1, 0, 1, 2);
    tbl[8]  = mk(1, 2'b00, 0, 2'b00, 2'b00, 0, 0, 1, 0);
    tbl[9]  = mk(1, 2'b11, 0, 2'b01, 2'b00, 1, 1, 0, 0);
    tbl[10] = mk(1, 2'b11, 0, 2'b00, 2'b00, 1, 0, 1, 0);
    tbl[11] = mk(1, 2'b11, 1, 2'b00, 2'b01, 1, 0, 1, 1);
    tbl[12] = mk(1, 2'b11, 0, 2'b00, 2'b00, 0, 0, 1, 0);
    tbl[13] = mk(1, 2'b11, 0, 2'b10, 2'b00, 1, 1, 0, 0);
    tbl[14] = mk(1, 2'b11, 0, 2'b00, 2'b00, 1, 0, 1, 0);
    tbl[15] = mk(1, 2'b11, 1, 2'b00, 2'b10, 1, 0, 1, 2);
    tbl[16] = mk(1, 2'b11, 0, 2'b00, 2'b00, 0, 0, 1, 0);
    tbl[17] = mk(1, 2'b11, 0, 2'b01, 2'b00, 1, 1, 0, 0);
    tbl[18] = mk(1, 2'b11, 0, 2'b00, 2'b00, 1, 0, 1, 0);
    tbl[19] = mk(1, 2'b11, 1, 2'b00, 2'b01, 1, 0, 1, 1);
    tbl[20] = mk(1, 2'b11, 0, 2'b00, 2'b00, 0, 0, 1, 0);
    tbl[21] = mk(1, 2'b11, 0, 2'b10, 2'b00, 1, 1, 0, 0);
    tbl[22] = mk(1, 2'b00, 0, 2'b00, 2'b00, 1, 0, 1, 0);
    tbl[23] = mk(1, 2'b00, 1, 2'b00, 2'b10, 1, 0, 1, 2);
    tbl[24] = mk(1, 2'b00, 0, 2'b00, 2'b00, 0, 0, 1, 0);
    tbl[25] = mk(1, 2'b00, 1, 2'b00, 2'b00, 0, 0, 1, 2);
    tbl[26] = mk(1, 2'b00, 0, 2'b00, 2'b00, 0, 0, 1, 0);
    tbl[27] = mk(1, 2'b01, 0, 2'b01, 2'b00, 1, 1, 0, 0);
    tbl[28] = mk(1, 2'b00, 1, 2'b00, 2'b00, 1, 0, 1, 0);
    tbl[29] = mk(1, 2'b00, 0, 2'b00, 2'b00, 1, 0, 1, 0);
    tbl[30] = mk(1, 2'b00, 1, 2'b00, 2'b01, 1, 0, 1, 1);
    tbl[31] = mk(1, 2'b00, 0, 2'b00, 2'b00, 0, 0, 1, 0);
    tbl[32] = mk(1, 2'b01, 0, 2'b01, 2'b00, 1, 1, 0, 0);
    tbl[33] = mk(1, 2'b00, 0, 2'b00, 2'b00, 1, 0, 1, 0);
    tbl[34] = mk(1, 2'b10, 1, 2'b00, 2'b01, 1, 0, 1, 1);
    tbl[35] = mk(1, 2'b10, 0, 2'b00, 2'b00, 0, 0, 1, 0);
    tbl[36] = mk(1, 2'b10, 0, 2'b10, 2'b00, 1, 1, 0, 0);
    tbl[37] = mk(1, 2'b00, 0, 2'b00, 2'b00, 1, 0, 1, 0);
    tbl[38] = mk(1, 2'b00, 1, 2'b00, 2'b10, 1, 0, 1, 2);
    tbl[39] = mk(1, 2'b00, 0, 2'b00, 2'b00, 0, 0, 1, 0);

    req_a   = {A1, A0};
    req_b   = {B1, B0};
    rst_n   = 1'b0;
    req     = '0;
    mm_done = 1'b0;

    for (int i = 0; i < 40; i++) begin
      rst_n   = tbl[i].rst;
      req     = tbl[i].rq;
      mm_done = tbl[i].dn;
      step();
      chk($sformatf("row%0d gnt", i),      256'(gnt),       256'(tbl[i].g));
      chk($sformatf("row%0d rsp_valid", i), 256'(rsp_valid), 256'(tbl[i].v));
      chk($sformatf("row%0d busy", i),     256'(busy),      256'(tbl[i].b));
      chk($sformatf("row%0d mm_start", i), 256'(mm_start),  256'(tbl[i].st));
      chk($sformatf("row%0d mm_rst_n", i), 256'(mm_rst_n),  256'(tbl[i].mr));
      chk($sformatf("row%0d rsp_err", i),  256'(rsp_err),   256'(0));
      if (tbl[i].osel != 2'd0) begin
        case (tbl[i].osel)
          2'd1:    exp_o = O0;
          2'd2:    exp_o = O1;
          default: exp_o = '0;
        endcase
        chk($sformatf("row%0d rsp_o", i), 256'(rsp_o), 256'(exp_o));
      end
    end

    // Reset for one cycle in the middle of WAIT, with the aborted done arriving around it.
    req = 2'b01; step();
    chk("abort gnt", 256'(gnt), 256'(2'b01));
    req = 2'b00; step();
    chk("abort in wait", 256'(mm_rst_n), 256'(1));
    rst_n = 1'b0; mm_done = 1'b1; step();
    chk("rst gnt", 256'(gnt), 256'(0));
    chk("rst rsp_valid", 256'(rsp_valid), 256'(0));
    chk("rst busy", 256'(busy), 256'(0));
    chk("rst mm_start", 256'(mm_start), 256'(0));
    chk("rst mm_rst_n", 256'(mm_rst_n), 256'(0));
    chk("rst rsp_o", 256'(rsp_o), 256'(0));
    chk("rst mm_a", 256'(mm_a), 256'(0));
    chk("rst mm_b", 256'(mm_b), 256'(0));
    chk("rst rsp_err", 256'(rsp_err), 256'(0));
    rst_n = 1'b1; step();
    chk("post rst rsp_valid", 256'(rsp_valid), 256'(0));
    chk("post rst busy", 256'(busy), 256'(0));
    mm_done = 1'b0; req = 2'b10; step();
    chk("solo1 gnt", 256'(gnt), 256'(2'b10));
    chk("solo1 mm_a", 256'(mm_a), 256'(A1));
    chk("solo1 mm_b", 256'(mm_b), 256'(B1));
    req = 2'b00; step();
    mm_done = 1'b1; step();
    chk("solo1 rsp_valid", 256'(rsp_valid), 256'(2'b10));
    chk("solo1 rsp_o", 256'(rsp_o), 256'(O1));
    mm_done = 1'b0; step();
    req = 2'b11; step();
    chk("pair after rst gnt", 256'(gnt), 256'(2'b01));
    req = 2'b10; step();
    mm_done = 1'b1; step();
    chk("pair0 rsp_valid", 256'(rsp_valid), 256'(2'b01));
    chk("pair0 rsp_o", 256'(rsp_o), 256'(O0));
    mm_done = 1'b0; step();
    step();
    chk("pair1 gnt", 256'(gnt), 256'(2'b10));
    req = 2'b00; step();
    mm_done = 1'b1; step();
    chk("pair1 rsp_valid", 256'(rsp_valid), 256'(2'b10));
    mm_done = 1'b0; step();

    // Matmul that never finishes.
    req = 2'b01; step();
    chk("stall gnt", 256'(gnt), 256'(2'b01));
    req = 2'b00;
`ifdef MATMUL_ARB_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("to wait%0d rsp_valid", i), 256'(rsp_valid), 256'(0));
    end
    step();
    chk("to rsp_valid", 256'(rsp_valid), 256'(2'b01));
    chk("to rsp_err", 256'(rsp_err), 256'(1));
    chk("to rsp_o", 256'(rsp_o), 256'(0));
    step();
    chk("to idle rsp_valid", 256'(rsp_valid), 256'(0));
    req = 2'b10; step();
    chk("to next gnt", 256'(gnt), 256'(2'b10));
    chk("to next mm_rst_n", 256'(mm_rst_n), 256'(0));
    req = 2'b00; step();
    mm_done = 1'b1; step();
    chk("to next rsp_valid", 256'(rsp_valid), 256'(2'b10));
    chk("to next rsp_err", 256'(rsp_err), 256'(0));
    chk("to next rsp_o", 256'(rsp_o), 256'(O1));
    mm_done = 1'b0; step();
`else
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("stall%0d rsp_valid", i), 256'(rsp_valid), 256'(0));
      chk($sformatf("stall%0d busy", i), 256'(busy), 256'(1));
    end
    mm_done = 1'b1; step();
    chk("stall end rsp_valid", 256'(rsp_valid), 256'(2'b01));
    chk("stall end rsp_o", 256'(rsp_o), 256'(O0));
    mm_done = 1'b0; step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
